// File: rtl/recv_frame_parser.sv
// rtl/recv_frame_parser.sv - byte-stream frame parser: header hunt, length, payload forward, checksum verify
module recv_frame_parser #(
    parameter logic [7:0]  HDR0        = 8'h55,
    parameter logic [7:0]  HDR1        = 8'hAA,
    parameter logic [15:0] TIMEOUT_CYC = 16'd1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fifo_rd_vld,
    input  logic [7:0]  fifo_rd_data,
    output logic        fifo_rd_en,
    output logic [7:0]  pl_data,
    output logic        pl_vld,
    input  logic        pl_rdy,
    output logic        pl_sop,
    output logic        pl_eop,
    output logic        frame_done,
    output logic        frame_err,
    output logic [15:0] frm_cnt,
    output logic [15:0] err_cnt
);

    localparam logic [2:0] S_HUNT0   = 3'd0;
    localparam logic [2:0] S_HUNT1   = 3'd1;
    localparam logic [2:0] S_LEN     = 3'd2;
    localparam logic [2:0] S_PAYLOAD = 3'd3;
    localparam logic [2:0] S_CSUM    = 3'd4;

    logic [2:0]  state;
    logic [15:0] timer;
    logic [7:0]  sum;
    logic [7:0]  count;
    logic        first;
    logic        accept;
    logic        timeout_hit;

    // In PAYLOAD the output register is the only buffer, so pop only when it can take a byte.
    assign fifo_rd_en  = !rst && ((state != S_PAYLOAD) || !pl_vld || pl_rdy);
    assign accept      = fifo_rd_vld && fifo_rd_en;
    assign timeout_hit = ({1'b0, timer} + 17'd1) >= {1'b0, TIMEOUT_CYC};

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_HUNT0;
            timer      <= 16'd0;
            sum        <= 8'd0;
            count      <= 8'd0;
            first      <= 1'b0;
            frm_cnt    <= 16'd0;
            err_cnt    <= 16'd0;
            pl_data    <= 8'h00;
            pl_vld     <= 1'b0;
            pl_sop     <= 1'b0;
            pl_eop     <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            if (pl_vld && pl_rdy) begin
                pl_vld <= 1'b0;
            end
            if (accept) begin
                timer <= 16'd0;
                case (state)
                    S_HUNT0: begin
                        if (fifo_rd_data == HDR0) state <= S_HUNT1;
                    end
                    S_HUNT1: begin
                        if (fifo_rd_data == HDR1)      state <= S_LEN;
                        else if (fifo_rd_data != HDR0) state <= S_HUNT0;
                    end
                    S_LEN: begin
                        if (fifo_rd_data == 8'd0) begin
                            frame_err <= 1'b1;
                            err_cnt   <= sat_inc(err_cnt);
                            state     <= S_HUNT0;
                        end else begin
                            count <= fifo_rd_data;
                            sum   <= fifo_rd_data;
                            first <= 1'b1;
                            state <= S_PAYLOAD;
                        end
                    end
                    S_PAYLOAD: begin
                        sum     <= sum + fifo_rd_data;
                        count   <= count - 8'd1;
                        first   <= 1'b0;
                        pl_data <= fifo_rd_data;
                        pl_vld  <= 1'b1;
                        pl_sop  <= first;
                        pl_eop  <= (count == 8'd1);
                        if (count == 8'd1) state <= S_CSUM;
                    end
                    S_CSUM: begin
                        if (fifo_rd_data == sum) begin
                            frame_done <= 1'b1;
                            frm_cnt    <= sat_inc(frm_cnt);
                        end else begin
                            frame_err <= 1'b1;
                            err_cnt   <= sat_inc(err_cnt);
                        end
                        state <= S_HUNT0;
                    end
                    default: state <= S_HUNT0;
                endcase
            end else if ((state != S_HUNT0) && !fifo_rd_vld) begin
                // Only true starvation counts; a stalled-but-valid FIFO is downstream backpressure.
                if (timeout_hit) begin
                    frame_err <= 1'b1;
                    err_cnt   <= sat_inc(err_cnt);
                    timer     <= 16'd0;
                    state     <= S_HUNT0;
                end else begin
                    timer <= timer + 16'd1;
                end
            end
        end
    end

endmodule
